// File: rtl/ldst_queue_unit_if.sv
// ldst_queue_unit_if: request/response handshake between the exec stage
// and the load/store unit.
interface ldst_queue_unit_if #(
    parameter int ADDR_W = 64,
    parameter int TAG_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic [TAG_W-1:0]  req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [TAG_W-1:0]  rsp_tag;
    logic [63:0]       rsp_data;
    logic              rsp_ovf;
    logic              rsp_fwd;

    modport master (
        output req_valid, req_op, req_size, req_addr, req_wdata, req_tag,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_tag, rsp_data, rsp_ovf, rsp_fwd
    );

    modport slave (
        input  req_valid, req_op, req_size, req_addr, req_wdata, req_tag,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_tag, rsp_data, rsp_ovf, rsp_fwd
    );
endinterface

// File: rtl/ldst_queue_unit.sv
// ldst_queue_unit: MMIX load/store unit with an in-order store queue.
// Define LSU_FWD_EN to enable store-to-load forwarding.
module ldst_queue_unit #(
    parameter int ADDR_W   = 64,
    parameter int SQ_DEPTH = 4,
    parameter int TAG_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    ldst_queue_unit_if.slave  lsu,
    output logic              sq_empty,
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_datasize,
    output logic              mem_read,
    output logic              mem_write,
    output logic [63:0]       mem_writedata,
    input  logic [63:0]       mem_readdata,
    input  logic              mem_done
);
    localparam int PTR_W = $clog2(SQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ} mstate_t;

    mstate_t state_q, state_d;

    logic [ADDR_W-1:0] sq_addr [SQ_DEPTH];
    logic [1:0]        sq_size [SQ_DEPTH];
    logic [63:0]       sq_data [SQ_DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;

    logic              rdy_q, ld_pend_q, sync_q, ld_sign_q;
    logic [ADDR_W-1:0] ld_addr_q;
    logic [1:0]        ld_size_q;
    logic [TAG_W-1:0]  ld_tag_q;
    logic [SQ_DEPTH-1:0] ld_wait_q;

    logic              rsp_valid_q, rsp_ovf_q;
    logic [TAG_W-1:0]  rsp_tag_q;
    logic [63:0]       rsp_data_q;

    logic              is_ld, is_st, is_sync;
    logic              acc, enq, deq, full, drained, ld_issue;
    logic [ADDR_W-1:0] amask, a_addr;
    logic [SQ_DEPTH-1:0] ovl, deq_mask;
    logic              fwd_ok, fwd_take;
    logic [63:0]       fwd_data;

    function automatic logic [63:0] trunc(input logic [63:0] d,
                                          input logic [1:0]  sz);
        case (sz)
            2'd0:    trunc = {56'b0, d[7:0]};
            2'd1:    trunc = {48'b0, d[15:0]};
            2'd2:    trunc = {32'b0, d[31:0]};
            default: trunc = d;
        endcase
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] d,
                                           input logic [1:0]  sz,
                                           input logic        sg);
        case (sz)
            2'd0:    extend = {{56{sg & d[7]}}, d[7:0]};
            2'd1:    extend = {{48{sg & d[15]}}, d[15:0]};
            2'd2:    extend = {{32{sg & d[31]}}, d[31:0]};
            default: extend = d;
        endcase
    endfunction

    function automatic logic ovf_of(input logic [63:0] d,
                                    input logic [1:0]  sz);
        case (sz)
            2'd0:    ovf_of = |d[63:8];
            2'd1:    ovf_of = |d[63:16];
            2'd2:    ovf_of = |d[63:32];
            default: ovf_of = 1'b0;
        endcase
    endfunction

    always_comb begin
        is_ld   = 1'b0;
        is_st   = 1'b0;
        is_sync = 1'b0;
        unique case (1'b1)
            !lsu.req_op[1]:       is_ld   = 1'b1;
            lsu.req_op == 2'd2:   is_st   = 1'b1;
            default:              is_sync = 1'b1;
        endcase
    end

    assign full     = count_q == CNT_W'(SQ_DEPTH);
    assign drained  = (count_q == '0) && (state_q != M_WRITE);
    assign sq_empty = drained;

    assign lsu.req_ready = rdy_q && !rsp_valid_q && !ld_pend_q
                         && !sync_q && !full;
    assign acc = lsu.req_valid && lsu.req_ready;
    assign enq = acc && is_st;
    assign deq = (state_q == M_WRITE) && mem_done;

    assign amask    = {ADDR_W{1'b1}} << lsu.req_size;
    assign a_addr   = lsu.req_addr & amask;
    assign deq_mask = deq ? (SQ_DEPTH'(1) << head_q) : '0;
    assign ld_issue = ld_pend_q && (ld_wait_q == '0);

    // Octa-granular overlap against every live entry, head included.
    always_comb begin
        ovl = '0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            ovl[i] = ({1'b0, PTR_W'(PTR_W'(i) - head_q)} < count_q)
                   && (sq_addr[i][ADDR_W-1:3] == a_addr[ADDR_W-1:3]);
        end
    end

`ifdef LSU_FWD_EN
    logic [PTR_W-1:0] yng, idx;
    logic             hit;
    logic             rsp_fwd_q;

    always_comb begin
        hit = 1'b0;
        yng = head_q;
        idx = head_q;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && ovl[idx]) begin
                hit = 1'b1;
                yng = idx;
            end
        end
        fwd_ok = hit && (sq_addr[yng] == a_addr)
               && (sq_size[yng] == lsu.req_size);
        fwd_data = extend(sq_data[yng], lsu.req_size, !lsu.req_op[0]);
    end

    // Every response is loaded while rsp_valid is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_fwd_q <= 1'b0;
        end else if (!rsp_valid_q) begin
            rsp_fwd_q <= fwd_take;
        end
    end

    assign lsu.rsp_fwd = rsp_fwd_q;
`else
    assign fwd_ok      = 1'b0;
    assign fwd_data    = '0;
    assign lsu.rsp_fwd = 1'b0;
`endif

    assign fwd_take = acc && is_ld && fwd_ok;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            M_IDLE: begin
                if (full)                 state_d = M_WRITE;
                else if (ld_issue)        state_d = M_READ;
                else if (count_q != '0)   state_d = M_WRITE;
            end
            M_WRITE: if (mem_done)        state_d = M_IDLE;
            M_READ:  if (mem_done)        state_d = M_IDLE;
            default:                      state_d = M_IDLE;
        endcase
    end

    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_datasize  = 2'd0;
        mem_writedata = '0;
        if (state_q == M_WRITE) begin
            mem_write     = 1'b1;
            mem_address   = sq_addr[head_q];
            mem_datasize  = sq_size[head_q];
            mem_writedata = sq_data[head_q];
        end else if (state_q == M_READ) begin
            mem_read      = 1'b1;
            mem_address   = ld_addr_q;
            mem_datasize  = ld_size_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= M_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q       <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ld_pend_q   <= 1'b0;
            sync_q      <= 1'b0;
            ld_sign_q   <= 1'b0;
            ld_addr_q   <= '0;
            ld_size_q   <= '0;
            ld_tag_q    <= '0;
            ld_wait_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                sq_addr[i] <= '0;
                sq_size[i] <= '0;
                sq_data[i] <= '0;
            end
        end else begin
            rdy_q   <= 1'b1;
            count_q <= count_q + CNT_W'(enq) - CNT_W'(deq);
            if (lsu.rsp_valid && lsu.rsp_ready) rsp_valid_q <= 1'b0;
            if (enq) begin
                sq_addr[tail_q] <= a_addr;
                sq_size[tail_q] <= lsu.req_size;
                sq_data[tail_q] <= trunc(lsu.req_wdata, lsu.req_size);
                tail_q          <= tail_q + PTR_W'(1);
                rsp_valid_q     <= 1'b1;
                rsp_tag_q       <= lsu.req_tag;
                rsp_data_q      <= '0;
                rsp_ovf_q       <= ovf_of(lsu.req_wdata, lsu.req_size);
            end
            if (deq) begin
                head_q    <= head_q + PTR_W'(1);
                ld_wait_q <= ld_wait_q & ~deq_mask;
            end
            if (acc && is_ld) begin
                if (fwd_take) begin
                    rsp_valid_q <= 1'b1;
                    rsp_tag_q   <= lsu.req_tag;
                    rsp_data_q  <= fwd_data;
                    rsp_ovf_q   <= 1'b0;
                end else begin
                    ld_pend_q <= 1'b1;
                    ld_addr_q <= a_addr;
                    ld_size_q <= lsu.req_size;
                    ld_sign_q <= !lsu.req_op[0];
                    ld_tag_q  <= lsu.req_tag;
                    ld_wait_q <= ovl & ~deq_mask;
                end
            end
            if (acc && is_sync) begin
                if (drained) begin
                    rsp_valid_q <= 1'b1;
                    rsp_tag_q   <= lsu.req_tag;
                    rsp_data_q  <= '0;
                    rsp_ovf_q   <= 1'b0;
                end else begin
                    sync_q   <= 1'b1;
                    ld_tag_q <= lsu.req_tag;
                end
            end
            if (sync_q && drained) begin
                sync_q      <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_tag_q   <= ld_tag_q;
                rsp_data_q  <= '0;
                rsp_ovf_q   <= 1'b0;
            end
            if ((state_q == M_READ) && mem_done) begin
                ld_pend_q   <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_tag_q   <= ld_tag_q;
                rsp_data_q  <= extend(mem_readdata, ld_size_q, ld_sign_q);
                rsp_ovf_q   <= 1'b0;
            end
        end
    end

    assign lsu.rsp_valid = rsp_valid_q;
    assign lsu.rsp_tag   = rsp_tag_q;
    assign lsu.rsp_data  = rsp_data_q;
    assign lsu.rsp_ovf   = rsp_ovf_q;
endmodule

// File: tb/tb_ldst_queue_unit.sv
// tb_ldst_queue_unit: scoreboard bench for the load/store queue unit.
// Responses and memory writes are predicted at issue and checked on arrival.
module tb_ldst_queue_unit;
    localparam int ADDR_W   = 64;
    localparam int SQ_DEPTH = 4;
    localparam int TAG_W    = 8;

    localparam logic [1:0] OP_LD = 2'd0, OP_LDU = 2'd1;
    localparam logic [1:0] OP_ST = 2'd2, OP_SYNC = 2'd3;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    ldst_queue_unit_if #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) lsu ();

    logic              sq_empty, mem_read, mem_write;
    logic              mem_done = 1'b0;
    logic [ADDR_W-1:0] mem_address;
    logic [1:0]        mem_datasize;
    logic [63:0]       mem_writedata;
    logic [63:0]       mem_readdata = '0;

    ldst_queue_unit #(
        .ADDR_W(ADDR_W), .SQ_DEPTH(SQ_DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .lsu(lsu),
        .sq_empty(sq_empty),
        .mem_address(mem_address),
        .mem_datasize(mem_datasize),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata),
        .mem_done(mem_done)
    );

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [63:0]      data;
        logic             ovf;
        logic             fwd;
    } rsp_t;

    typedef struct {
        logic [63:0] addr;
        logic [1:0]  sz;
        logic [63:0] data;
    } wr_t;

    rsp_t exp_rsp[$];
    wr_t  exp_wr[$];
    rsp_t mr;
    wr_t  mw;

    int total = 0;
    int bad = 0;
    int mem_lat = 1;
    int busy = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int rd_wr_snap = 0;
    logic [63:0] rd_val = '0;
    logic [TAG_W-1:0] tag_n = '0;

`ifdef LSU_FWD_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Memory: completes each access mem_lat cycles after it appears.
    always @(negedge clk) begin
        mem_done = 1'b0;
        if (!reset_n) begin
            busy = 0;
        end else if (mem_read || mem_write) begin
            busy++;
            if (busy >= mem_lat) begin
                busy = 0;
                mem_done = 1'b1;
                if (mem_write) begin
                    wr_cnt++;
                    if (exp_wr.size() == 0) begin
                        chk("wr_extra", 1, 0);
                    end else begin
                        mw = exp_wr.pop_front();
                        chk("wr_addr", mem_address, mw.addr);
                        chk("wr_size", 64'(mem_datasize), 64'(mw.sz));
                        chk("wr_data", mem_writedata, mw.data);
                    end
                end else begin
                    rd_cnt++;
                    rd_wr_snap = wr_cnt;
                    mem_readdata = rd_val;
                end
            end
        end else begin
            busy = 0;
        end
    end

    always @(negedge clk) begin
        if (reset_n && lsu.rsp_valid && lsu.rsp_ready) begin
            if (exp_rsp.size() == 0) begin
                chk("rsp_extra", 1, 0);
            end else begin
                mr = exp_rsp.pop_front();
                chk("rsp_tag", 64'(lsu.rsp_tag), 64'(mr.tag));
                chk("rsp_data", lsu.rsp_data, mr.data);
                chk("rsp_ovf", 64'(lsu.rsp_ovf), 64'(mr.ovf));
                chk("rsp_fwd", 64'(lsu.rsp_fwd), 64'(mr.fwd));
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [1:0] sz,
                        input logic [63:0] a, input logic [63:0] d,
                        input logic [63:0] ld_exp, input logic fwd_exp);
        rsp_t r;
        wr_t  w;
        int   n = 0;
        logic [63:0] m;
        @(negedge clk);
        lsu.req_valid = 1'b1;
        lsu.req_op    = op;
        lsu.req_size  = sz;
        lsu.req_addr  = a;
        lsu.req_wdata = d;
        lsu.req_tag   = tag_n;
        while (!lsu.req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            chk("req_timeout", 0, 1);
            lsu.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 lsu.req_valid = 1'b0;
        m = (sz == 2'd3) ? '1 : ((64'd1 << (8 << sz)) - 64'd1);
        r.tag  = tag_n;
        r.data = '0;
        r.ovf  = 1'b0;
        r.fwd  = 1'b0;
        if (op == OP_ST) begin
            r.ovf  = (d & ~m) != '0;
            w.addr = a & ~((64'd1 << sz) - 64'd1);
            w.sz   = sz;
            w.data = d & m;
            exp_wr.push_back(w);
        end else if (op != OP_SYNC) begin
            r.data = ld_exp;
            r.fwd  = fwd_exp;
        end
        exp_rsp.push_back(r);
        tag_n++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_rsp.size() != 0 || !sq_empty || mem_read) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(n < 500), 1);
    endtask

    initial begin
        int base_w, base_r, n;
        logic [TAG_W-1:0] stag;
        lsu.req_valid = 1'b0;
        lsu.req_op    = '0;
        lsu.req_size  = '0;
        lsu.req_addr  = '0;
        lsu.req_wdata = '0;
        lsu.req_tag   = '0;
        lsu.rsp_ready = 1'b0;

        #2 reset_n = 1'b0;
        #1;
        chk("rst_req_ready", 64'(lsu.req_ready), 0);
        chk("rst_rsp_valid", 64'(lsu.rsp_valid), 0);
        chk("rst_mem_read", 64'(mem_read), 0);
        chk("rst_mem_write", 64'(mem_write), 0);
        chk("rst_sq_empty", 64'(sq_empty), 1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1 chk("rel_ready_low", 64'(lsu.req_ready), 0);
        @(posedge clk);
        #1 chk("rel_ready_high", 64'(lsu.req_ready), 1);
        lsu.rsp_ready = 1'b1;

        // Stores: overflow, byte lane and octa alignment.
        mem_lat = 1;
        send(OP_ST, 2'd0, 64'h1003, 64'h1FF, '0, 1'b0);
        send(OP_ST, 2'd3, 64'h2007, 64'h5, '0, 1'b0);
        wait_idle();

        // Loads from memory with sign and zero extension.
        rd_val = 64'h1234_5680;
        send(OP_LD, 2'd0, 64'h3001, '0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        send(OP_LDU, 2'd0, 64'h3001, '0, 64'h80, 1'b0);
        wait_idle();
        rd_val = 64'h8000_0000_0000_0001;
        send(OP_LD, 2'd3, 64'h3000, '0, 64'h8000_0000_0000_0001, 1'b0);
        wait_idle();

        // Exact-match wyde behind an unrelated store.
        mem_lat = 8;
        rd_val  = 64'h8001;
        base_w  = wr_cnt;
        base_r  = rd_cnt;
        send(OP_ST, 2'd3, 64'h100, 64'hAA, '0, 1'b0);
        send(OP_ST, 2'd1, 64'h40, 64'h8001, '0, 1'b0);
        send(OP_LD, 2'd1, 64'h41, '0, 64'hFFFF_FFFF_FFFF_8001, FWD_ON);
        wait_idle();
        if (FWD_ON) begin
            chk("fwd_no_read", 64'(rd_cnt - base_r), 0);
        end else begin
            chk("nofwd_read", 64'(rd_cnt - base_r), 1);
            chk("nofwd_order", 64'(rd_wr_snap), 64'(base_w + 2));
        end

        // Partial overlap must drain before the memory read.
        rd_val = 64'h8000_0000;
        base_w = wr_cnt;
        base_r = rd_cnt;
        send(OP_ST, 2'd3, 64'h200, 64'h1, '0, 1'b0);
        send(OP_ST, 2'd0, 64'h40, 64'h11, '0, 1'b0);
        send(OP_LDU, 2'd2, 64'h40, '0, 64'h0000_0000_8000_0000, 1'b0);
        wait_idle();
        chk("part_read", 64'(rd_cnt - base_r), 1);
        chk("part_order", 64'(rd_wr_snap), 64'(base_w + 2));
        send(OP_LD, 2'd2, 64'h44, '0, 64'hFFFF_FFFF_8000_0000, 1'b0);
        wait_idle();

        // Fill past capacity with slow memory; pointers wrap.
        mem_lat = 12;
        base_w  = wr_cnt;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            send(OP_ST, 2'd3, 64'h1000 + 64'(8 * i), 64'h100 + 64'(i), '0, 1'b0);
        end
        @(negedge clk);
        @(negedge clk);
        chk("full_ready", 64'(lsu.req_ready), 0);
        chk("full_not_empty", 64'(sq_empty), 0);
        send(OP_ST, 2'd3, 64'h1100, 64'h1FF, '0, 1'b0);
        wait_idle();
        chk("fill_writes", 64'(wr_cnt - base_w), 64'(SQ_DEPTH + 1));

        // SYNCD waits for three stores, then holds while unconsumed.
        mem_lat = 3;
        base_w  = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            send(OP_ST, 2'd2, 64'h6000 + 64'(4 * i), 64'h7 + 64'(i), '0, 1'b0);
        end
        @(negedge clk);
        @(posedge clk);
        #1 lsu.rsp_ready = 1'b0;
        stag = tag_n;
        send(OP_SYNC, 2'd0, '0, '0, '0, 1'b0);
        n = 0;
        while (!lsu.rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sync_seen", 64'(lsu.rsp_valid), 1);
        chk("sync_drained", 64'(wr_cnt - base_w), 3);
        chk("sync_empty", 64'(sq_empty), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sync_hold", 64'(lsu.rsp_valid), 1);
            chk("sync_tag", 64'(lsu.rsp_tag), 64'(stag));
        end
        @(posedge clk);
        #1 lsu.rsp_ready = 1'b1;
        wait_idle();

        // Reset in the middle of a write drops the queue.
        mem_lat = 50;
        send(OP_ST, 2'd3, 64'h7000, 64'h1, '0, 1'b0);
        send(OP_ST, 2'd3, 64'h7008, 64'h2, '0, 1'b0);
        n = 0;
        while (!mem_write && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_write", 64'(mem_write), 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_drop_write", 64'(mem_write), 0);
        chk("rst_drop_empty", 64'(sq_empty), 1);
        chk("rst_drop_ready", 64'(lsu.req_ready), 0);
        chk("rst_drop_rsp", 64'(lsu.rsp_valid), 0);
        exp_wr.delete();
        exp_rsp.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 chk("rst2_ready", 64'(lsu.req_ready), 1);
        mem_lat = 1;
        send(OP_ST, 2'd3, 64'h5000, 64'h77, '0, 1'b0);
        wait_idle();

        chk("rsp_left", 64'(exp_rsp.size()), 0);
        chk("wr_left", 64'(exp_wr.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
